// File: rtl/yangmips_defines.sv
// Shared yangMIPS definitions: divider state encodings, handshake levels and word widths.
package yangmips_defines;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned DWORD_W = 64;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/yangmips_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
module yangmips_div
    import yangmips_defines::*;
#(
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    div_state_e state_q, state_d;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W:0]   work_q, work_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                signed_q, signed_d;
    logic                sign1_q, sign1_d;
    logic                sign2_q, sign2_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quo, rem;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (annul_i) begin
            state_d = DIV_FREE;
        end else begin
            unique case (state_q)
                DIV_FREE: begin
                    if (start_i == DIV_START) begin
                        state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: state_d = DIV_END;
                DIV_ON: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = DIV_END;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state_d = DIV_FREE;
                    end
                end
                default: state_d = DIV_FREE;
            endcase
        end
    end

    assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    assign diff    = work_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};

    always_comb begin
        quo = work_q[DATA_W-1:0];
        rem = work_q[2*DATA_W:DATA_W+1];
        if (signed_q && (sign1_q ^ sign2_q)) begin
            quo = -work_q[DATA_W-1:0];
        end
        if (signed_q && sign1_q) begin
            rem = -work_q[2*DATA_W:DATA_W+1];
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        result_d  = result_q;
        ready_d   = ready_q;
        if (annul_i) begin
            cnt_d    = '0;
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
        end else begin
            unique case (state_q)
                DIV_FREE: begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                    if (start_i == DIV_START && opdata2_i != '0) begin
                        cnt_d     = '0;
                        // Dividend sits one bit up so its MSB enters the compare window on the
                        // first step; remainder then lands at the top after DATA_W steps.
                        work_d    = {{DATA_W{1'b0}}, op1_abs, 1'b0};
                        divisor_d = op2_abs;
                        signed_d  = signed_div_i;
                        sign1_d   = opdata1_i[DATA_W-1];
                        sign2_d   = opdata2_i[DATA_W-1];
                    end
                end
                DIV_BYZERO: begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (cnt_q != CNT_LAST) begin
                        if (diff[DATA_W]) begin
                            work_d = {work_q[2*DATA_W-1:0], 1'b0};
                        end else begin
                            work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        result_d = {rem, quo};
                        ready_d  = DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        result_d = '0;
                        ready_d  = DIV_RESULT_NOT_READY;
                    end
                end
                default: begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_yangmips_div.sv
// Directed self-checking bench for yangmips_div with hand-computed DIV/DIVU results.
module tb_yangmips_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks   = 0;
    int failures = 0;

    yangmips_div #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Start a division at the next falling edge, then count edges after the sampling
    // edge until ready_o is seen (bounded). Leaves start_i high.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output logic [63:0] res);
        logic done;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (ready_o) done = 1'b1;
        end
        res = result_o;
    endtask

    task automatic release_start(input string name);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL %s_release: ready=%b result=%h, expected ready=0 result=0",
                     name, ready_o, result_o);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL reset: ready=%b result=%h, expected ready=0 result=0",
                     ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned_latency();
        int          cycles;
        logic        done;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        // Operands change after sampling; the running division must ignore them.
        @(negedge clk);
        opdata1_i    = 32'hDEADBEEF;
        opdata2_i    = 32'h0;
        signed_div_i = 1'b1;
        cycles = 1;
        done   = ready_o;
        while (!done && cycles < 100) begin
            @(posedge clk);
            #1;
            if (ready_o) done = 1'b1;
            else cycles++;
        end
        checks++;
        if (cycles !== 33) begin
            failures++;
            $display("FAIL udiv_latency: ready after %0d cycles, expected 33", cycles);
        end
        checks++;
        if (result_o !== 64'h00000002_0000000E) begin
            failures++;
            $display("FAIL udiv_100_7: result=%h, expected 000000020000000e", result_o);
        end
        // Result must hold while start_i stays high.
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
            failures++;
            $display("FAIL udiv_hold: ready=%b result=%h, expected ready=1 result=000000020000000e",
                     ready_o, result_o);
        end
        release_start("udiv");
    endtask

    task automatic test_signed();
        int          cycles;
        logic [63:0] res;
        do_div(1'b1, 32'hFFFFFFF9, 32'h00000002, cycles, res);
        checks++;
        if (res !== 64'hFFFFFFFF_FFFFFFFD || cycles !== 33) begin
            failures++;
            $display("FAIL sdiv_m7_2: result=%h cycles=%0d, expected fffffffffffffffd cycles=33",
                     res, cycles);
        end
        release_start("sdiv");
        do_div(1'b0, 32'hFFFFFFF9, 32'h00000002, cycles, res);
        checks++;
        if (res !== 64'h00000001_7FFFFFFC) begin
            failures++;
            $display("FAIL udiv_fff9_2: result=%h, expected 000000017ffffffc", res);
        end
        release_start("udiv2");
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, cycles, res);
        checks++;
        if (res !== 64'h00000001_FFFFFFFD) begin
            failures++;
            $display("FAIL sdiv_7_m2: result=%h, expected 00000001fffffffd", res);
        end
        release_start("sdiv2");
    endtask

    task automatic test_divzero();
        int          cycles;
        logic [63:0] res;
        do_div(1'b1, 32'h12345678, 32'h0, cycles, res);
        checks++;
        if (cycles !== 1 || res !== 64'h0) begin
            failures++;
            $display("FAIL divzero: ready after %0d cycles result=%h, expected 1 cycle result=0",
                     cycles, res);
        end
        release_start("divzero");
    endtask

    task automatic test_annul();
        int          cycles;
        logic [63:0] res;
        logic        seen;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL annul_edge: ready=%b result=%h, expected ready=0 result=0",
                     ready_o, result_o);
        end
        @(negedge clk);
        annul_i = 1'b0;
        seen    = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL annul_no_ready: ready seen=%b, expected 0", seen);
        end
        do_div(1'b0, 32'hFFFFFFFF, 32'h00000001, cycles, res);
        checks++;
        if (cycles !== 33 || res !== 64'h00000000_FFFFFFFF) begin
            failures++;
            $display("FAIL after_annul: cycles=%0d result=%h, expected 33 00000000ffffffff",
                     cycles, res);
        end
        release_start("after_annul");
    endtask

    task automatic test_rst_mid();
        int          cycles;
        logic [63:0] res;
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'h80000000;
        opdata2_i    = 32'hFFFFFFFF;
        start_i      = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++;
            $display("FAIL rst_mid: ready=%b result=%h, expected ready=0 result=0",
                     ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, cycles, res);
        checks++;
        if (cycles !== 33 || res !== 64'h00000000_80000000) begin
            failures++;
            $display("FAIL sdiv_min_m1: cycles=%0d result=%h, expected 33 0000000080000000",
                     cycles, res);
        end
        release_start("sdiv_min");
    endtask

    task automatic test_back_to_back();
        int          cycles;
        logic [63:0] res;
        do_div(1'b0, 32'd1000, 32'd10, cycles, res);
        checks++;
        if (res !== 64'h00000000_00000064) begin
            failures++;
            $display("FAIL b2b_first: result=%h, expected 0000000000000064", res);
        end
        release_start("b2b");
        do_div(1'b0, 32'hFFFFFFFF, 32'h00000010, cycles, res);
        checks++;
        if (cycles !== 33 || res !== 64'h0000000F_0FFFFFFF) begin
            failures++;
            $display("FAIL b2b_second: cycles=%0d result=%h, expected 33 0000000f0fffffff",
                     cycles, res);
        end
        release_start("b2b2");
    endtask

    initial begin
        test_reset();
        test_unsigned_latency();
        test_signed();
        test_divzero();
        test_annul();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
